// File: rtl/fibo_controller.sv
// Moore FSM sequencing the Fibonacci datapath: loads n/constants, iterates (a,b)->(b,a+b), presents F(n).
// Latency: done rises 4n+6 cycles after start is accepted; start is sampled only in IDLE and DONE.
module fibo_controller #(
    parameter int unsigned size     = 4,
    parameter logic [2:0]  OP_ADD   = 3'b000,
    parameter logic [2:0]  OP_SUB   = 3'b001,
    parameter logic [2:0]  OP_PASSA = 3'b010
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            start,
    input  logic [size-1:0] n_in,
    input  logic            zero_flag,
    output logic [1:0]      wrt_adder,
    output logic            wrt_en,
    output logic            load_data,
    output logic [1:0]      rd_addr1,
    output logic [1:0]      rd_addr2,
    output logic [2:0]      alu_opcode,
    output logic [size-1:0] count,
    output logic            busy,
    output logic            done
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOAD_N   = 4'd1;
    localparam logic [3:0] S_LOAD_ONE = 4'd2;
    localparam logic [3:0] S_LOAD_A   = 4'd3;
    localparam logic [3:0] S_LOAD_B   = 4'd4;
    localparam logic [3:0] S_CHECK    = 4'd5;
    localparam logic [3:0] S_ADD_B    = 4'd6;
    localparam logic [3:0] S_SUB_A    = 4'd7;
    localparam logic [3:0] S_DEC      = 4'd8;
    localparam logic [3:0] S_OUT      = 4'd9;
    localparam logic [3:0] S_DONE     = 4'd10;

    localparam logic [size-1:0] ONE = size'(1);

    logic [3:0]      state_q, state_d;
    logic [size-1:0] n_reg_q, n_reg_d;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            n_reg_q <= '0;
        end else begin
            state_q <= state_d;
            n_reg_q <= n_reg_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        n_reg_d = n_reg_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_N;
                    n_reg_d = n_in;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_N:   state_d = S_LOAD_ONE;
            S_LOAD_ONE: state_d = S_LOAD_A;
            S_LOAD_A:   state_d = S_LOAD_B;
            S_LOAD_B:   state_d = S_CHECK;
            S_CHECK:    state_d = zero_flag ? S_OUT : S_ADD_B;
            S_ADD_B:    state_d = S_SUB_A;
            S_SUB_A:    state_d = S_DEC;
            S_DEC:      state_d = S_CHECK;
            S_OUT:      state_d = S_DONE;
            S_DONE:     state_d = start ? S_DONE : S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Pure state decode; unused encodings fall through to the IDLE defaults.
    always_comb begin
        wrt_adder  = 2'd0;
        wrt_en     = 1'b0;
        load_data  = 1'b0;
        rd_addr1   = 2'd0;
        rd_addr2   = 2'd0;
        alu_opcode = OP_PASSA;
        count      = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_LOAD_N: begin
                wrt_en = 1'b1; load_data = 1'b1; wrt_adder = 2'd2; count = n_reg_q; busy = 1'b1;
            end
            S_LOAD_ONE: begin
                wrt_en = 1'b1; load_data = 1'b1; wrt_adder = 2'd3; count = ONE; busy = 1'b1;
            end
            S_LOAD_A: begin
                wrt_en = 1'b1; load_data = 1'b1; wrt_adder = 2'd0; count = '0; busy = 1'b1;
            end
            S_LOAD_B: begin
                wrt_en = 1'b1; load_data = 1'b1; wrt_adder = 2'd1; count = ONE; busy = 1'b1;
            end
            S_CHECK: begin
                rd_addr1 = 2'd2; alu_opcode = OP_PASSA; busy = 1'b1;
            end
            S_ADD_B: begin
                wrt_en = 1'b1; wrt_adder = 2'd1; rd_addr1 = 2'd0; rd_addr2 = 2'd1;
                alu_opcode = OP_ADD; busy = 1'b1;
            end
            // a <= (a+b) - a leaves the old b in R0 without a swap register.
            S_SUB_A: begin
                wrt_en = 1'b1; wrt_adder = 2'd0; rd_addr1 = 2'd1; rd_addr2 = 2'd0;
                alu_opcode = OP_SUB; busy = 1'b1;
            end
            S_DEC: begin
                wrt_en = 1'b1; wrt_adder = 2'd2; rd_addr1 = 2'd2; rd_addr2 = 2'd3;
                alu_opcode = OP_SUB; busy = 1'b1;
            end
            S_OUT: begin
                rd_addr1 = 2'd0; alu_opcode = OP_PASSA; busy = 1'b1;
            end
            S_DONE: begin
                rd_addr1 = 2'd0; alu_opcode = OP_PASSA; done = 1'b1;
            end
            default: begin
                wrt_en = 1'b0;
            end
        endcase
    end

endmodule
